// File: rtl/rc5_pkg.sv
// ----------------------------------------------------------------------------
// rc5_pkg
// Shared definitions for the RC5 block: the magic constants used by the key
// expansion side, the decryptor FSM state encoding and a helper that derives
// the S-table address width from the table length.
// ----------------------------------------------------------------------------
package rc5_pkg;

  // Magic constants Pw / Qw for the three legal word widths.
  localparam logic [15:0] P16 = 16'hB7E1;
  localparam logic [15:0] Q16 = 16'h9E37;
  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;
  localparam logic [63:0] P64 = 64'hB7E151628AED2A6B;
  localparam logic [63:0] Q64 = 64'h9E3779B97F4A7C15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } rc5_state_t;

  // Address width for a table of t words; never narrower than one bit.
  function automatic int calc_aw(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/rc5_rotr.sv
// ----------------------------------------------------------------------------
// rc5_rotr
// Combinational variable right rotate.
//   data   in  w       word to rotate
//   amt    in  log2(w) rotate amount (only the low log2(w) bits of the RC5
//                      rotate operand are ever presented here)
//   result out w       data rotated right by amt
// ----------------------------------------------------------------------------
module rc5_rotr #(
  parameter int w  = 32,
  parameter int lw = $clog2(w)
) (
  input  logic [w-1:0]  data,
  input  logic [lw-1:0] amt,
  output logic [w-1:0]  result
);

  // Left-shift distance is w - amt; one extra bit holds w itself when amt is
  // zero, and a shift by w clears the term so the rotate degenerates cleanly.
  logic [lw:0] lshift;

  assign lshift = (lw+1)'(w) - {1'b0, amt};
  assign result = (data >> amt) | (data << lshift);

endmodule

// File: rtl/rc5_decrypt_core.sv
// ----------------------------------------------------------------------------
// rc5_decrypt_core
// Iterative RC5-w/r block decryptor, one half-round per clock. The expanded
// key table S lives in the key-expansion block and is read here through a
// combinational port, walking the table from S[t-1] down to S[0].
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   request, sampled only in IDLE
//   din_a   in   ciphertext word A, captured on the accepting edge
//   din_b   in   ciphertext word B, captured on the accepting edge
//   s_addr  out  S-table read address (idx in STEP, 0 otherwise)
//   s_data  in   S[s_addr], valid in the same cycle
//   busy    out  high in STEP and DONE
//   done    out  one-cycle pulse, result valid
//   dout_a  out  plaintext word A (valid from DONE until the next start)
//   dout_b  out  plaintext word B
// ----------------------------------------------------------------------------
module rc5_decrypt_core
  import rc5_pkg::*;
#(
  parameter int w  = 32,
  parameter int r  = 12,
  parameter int t  = 2*r+2,
  parameter int aw = calc_aw(t)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [w-1:0]  din_a,
  input  logic [w-1:0]  din_b,
  output logic [aw-1:0] s_addr,
  input  logic [w-1:0]  s_data,
  output logic          busy,
  output logic          done,
  output logic [w-1:0]  dout_a,
  output logic [w-1:0]  dout_b
);

  localparam int lw = $clog2(w);

  rc5_state_t    state;
  logic [w-1:0]  a_q;
  logic [w-1:0]  b_q;
  logic [aw-1:0] idx_q;

  logic [w-1:0]  a_sub;
  logic [w-1:0]  b_sub;
  logic [w-1:0]  a_rot;
  logic [w-1:0]  b_rot;

  // Both half-round datapaths are built every cycle; the FSM picks which
  // register takes its result from the parity of idx.
  assign a_sub = a_q - s_data;
  assign b_sub = b_q - s_data;

  // A path rotates by B, B path rotates by A (low log2(w) bits only).
  rc5_rotr #(.w(w)) u_rotr_a (
    .data   (a_sub),
    .amt    (b_q[lw-1:0]),
    .result (a_rot)
  );

  rc5_rotr #(.w(w)) u_rotr_b (
    .data   (b_sub),
    .amt    (a_q[lw-1:0]),
    .result (b_rot)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // in this block samples the pre-edge values of a_q/b_q/idx_q, which is
  // what lets the datapath above read A while B is being written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= din_a;
            b_q   <= din_b;
            idx_q <= aw'(t-1);
            busy  <= 1'b1;
            state <= STEP;
          end
        end

        STEP: begin
          if (idx_q == '0) begin
            // Final pre-whitening undo on A; result is complete.
            a_q   <= a_sub;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx_q <= idx_q - aw'(1);
            if (idx_q == aw'(1)) begin
              b_q <= b_sub;
            end else if (idx_q[0]) begin
              b_q <= b_rot ^ a_q;
            end else begin
              a_q <= a_rot ^ b_q;
            end
          end
        end

        DONE: begin
          // start is ignored here; the earliest next accept is in IDLE.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign s_addr = (state == STEP) ? idx_q : '0;
  assign dout_a = a_q;
  assign dout_b = b_q;

endmodule
